// File: rtl/safecrack_pkg.sv
// Shared types and constants for the safe-lock key front end.
// One-hot FSM encoding, key bus width and default timing parameters.
package safecrack_pkg;

   localparam int KEY_W               = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 250000;
   localparam int DEF_LONG_CYCLES     = 100000000;

   typedef enum logic [3:0] {
      ST_IDLE         = 4'b0001,
      ST_PRESS_WAIT   = 4'b0010,
      ST_HELD         = 4'b0100,
      ST_RELEASE_WAIT = 4'b1000
   } key_state_t;

endpackage

// File: rtl/safecrack_sync2.sv
// Two-flop synchroniser, WIDTH bits, asynchronous reset to 0.
// Latency 2 cycles; no flow control.
module safecrack_sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/safecrack_key_frontend.sv
// Debounces active-low keys and emits one single-cycle btn code per press episode, plus long-press pulse.
// btn valid DEBOUNCE_CYCLES+3 cycles after a stable key change; no backpressure, outputs registered.
module safecrack_key_frontend
   import safecrack_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_n,
   output logic [KEY_W-1:0] btn,
   output logic             long_press,
   output logic             busy
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int                HCNT_W   = $clog2(LONG_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_CYCLES);

   logic [KEY_W-1:0]  key_raw;
   logic [KEY_W-1:0]  s;

   key_state_t        state_q;
   logic [KEY_W-1:0]  cand_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [HCNT_W-1:0] hcnt_q;
   logic              long_done_q;
   logic [KEY_W-1:0]  btn_q;
   logic              long_q;
   logic              busy_q;

   assign key_raw = ~key_n;

   safecrack_sync2 #(
      .WIDTH (KEY_W)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (key_raw),
      .q_o (s)
   );

   // long_done starts set so an episode that was never emitted cannot raise long_press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RELEASE_WAIT;
         cand_q      <= '0;
         cnt_q       <= '0;
         hcnt_q      <= '0;
         long_done_q <= 1'b1;
         btn_q       <= '0;
         long_q      <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         btn_q  <= '0;
         long_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s != '0) begin
                  state_q <= ST_PRESS_WAIT;
                  cand_q  <= s;
                  cnt_q   <= CNT_W'(1);
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            ST_PRESS_WAIT: begin
               if (s == '0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (s != cand_q) begin
                  cand_q  <= s;
                  cnt_q   <= CNT_W'(1);
               end else if (cnt_q == CNT_MAX) begin
                  btn_q       <= cand_q;
                  hcnt_q      <= HCNT_W'(1);
                  long_done_q <= 1'b0;
                  state_q     <= ST_HELD;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HELD: begin
               if (s == '0) begin
                  state_q <= ST_RELEASE_WAIT;
                  cnt_q   <= CNT_W'(1);
               end else if (hcnt_q == HCNT_MAX) begin
                  if (!long_done_q) begin
                     long_q      <= 1'b1;
                     long_done_q <= 1'b1;
                  end
               end else begin
                  hcnt_q <= hcnt_q + HCNT_W'(1);
               end
            end
            ST_RELEASE_WAIT: begin
               if (s != '0) begin
                  state_q <= ST_HELD;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_RELEASE_WAIT;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign btn        = btn_q;
   assign long_press = long_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_safecrack_key_frontend.sv
// Scoreboard bench for safecrack_key_frontend with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Expected btn/long_press pulses are queued with their cycle number at stimulus time.
module tb_safecrack_key_frontend;

   localparam int DEB = 4;
   localparam int LNG = 20;
   localparam int BTN_LAT = DEB + 3;

   logic       clk;
   logic       rst;
   logic [3:0] key_n;
   logic [3:0] btn;
   logic       long_press;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [3:0] code;
   } exp_t;

   exp_t exp_btn[$];
   int   exp_lp[$];
   exp_t mon_e;
   int   mon_c;

   safecrack_key_frontend #(
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LNG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n),
      .btn        (btn),
      .long_press (long_press),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Every non-zero btn / long_press cycle must match the head of its queue.
   always @(negedge clk) begin
      if (btn !== 4'b0000) begin
         if (exp_btn.size() == 0) begin
            check_eq("btn_unexpected", {28'd0, btn}, 32'd0);
         end else begin
            mon_e = exp_btn.pop_front();
            check_eq("btn_cycle", cyc, mon_e.cyc);
            check_eq("btn_code", {28'd0, btn}, {28'd0, mon_e.code});
         end
      end
      if (long_press !== 1'b0) begin
         if (exp_lp.size() == 0) begin
            check_eq("long_unexpected", {31'd0, long_press}, 32'd0);
         end else begin
            mon_c = exp_lp.pop_front();
            check_eq("long_cycle", cyc, mon_c);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] k, input int n);
      key_n = k;
      step(n);
   endtask

   // Final stable change: queue the pulse it must produce, then hold.
   task automatic press_exp(input logic [3:0] k, input int n);
      exp_t e;
      e.cyc  = cyc + BTN_LAT;
      e.code = ~k;
      exp_btn.push_back(e);
      drive(k, n);
   endtask

   task automatic release_to_idle(input string tag);
      key_n = 4'b1111;
      step(BTN_LAT - 1);
      check_eq({tag, "_busy_before_idle"}, {31'd0, busy}, 32'd1);
      step(1);
      check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_btn_pending"}, exp_btn.size(), 32'd0);
      check_eq({tag, "_long_pending"}, exp_lp.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      key_n = 4'b1110;
      step(3);
      check_eq("rst_btn", {28'd0, btn}, 32'd0);
      check_eq("rst_long", {31'd0, long_press}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd1);

      // Key held through reset: never emitted.
      rst = 1'b0;
      step(6);
      check_eq("held_rst_busy", {31'd0, busy}, 32'd1);
      release_to_idle("held_rst");
      step(5);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);

      // Clean single-key press.
      press_exp(4'b1000, 15);
      check_eq("clean_busy_held", {31'd0, busy}, 32'd1);
      release_to_idle("clean");
      step(3);

      // Bouncy press: only the final stable pattern is emitted.
      for (int i = 0; i < 4; i++) begin
         drive(((i % 2) == 0) ? 4'b0010 : 4'b1111, 2);
      end
      press_exp(4'b0010, 12);
      release_to_idle("bouncy");
      step(3);

      // Release bounce while HELD, including a chord change.
      press_exp(4'b1011, 9);
      drive(4'b1111, 1);
      drive(4'b1011, 2);
      drive(4'b1111, 3);
      check_eq("relb_busy_mid", {31'd0, busy}, 32'd1);
      drive(4'b1011, 1);
      drive(4'b1111, 2);
      drive(4'b0011, 2);
      release_to_idle("relb");
      step(3);

      // Long press, then a release bounce must not repeat it.
      exp_lp.push_back(cyc + BTN_LAT + LNG);
      press_exp(4'b0111, BTN_LAT + 30);
      drive(4'b1111, 2);
      drive(4'b0111, 3);
      release_to_idle("long");
      step(3);

      // Async reset mid-PRESS_WAIT with key still held.
      drive(4'b1101, 4);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_btn", {28'd0, btn}, 32'd0);
      check_eq("arst_busy", {31'd0, busy}, 32'd1);
      check_eq("arst_long", {31'd0, long_press}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(15);
      release_to_idle("arst");
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
